// File: rtl/reaction_pkg.sv
// Shared definitions for the multi-player reaction timer.
//   - state_e  : FSM state encoding (also the value driven on the state output)
//   - RES_*    : per-player result codes
//   - LFSR_TAPS: Galois tap mask for x^16+x^14+x^13+x^11+1
//   - lfsr_step: one right-shifting Galois LFSR step
package reaction_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StCountdown = 2'd1,
    StTest      = 2'd2,
    StResult    = 2'd3
  } state_e;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_GOOD  = 2'b01;
  localparam logic [1:0] RES_EARLY = 2'b10;
  localparam logic [1:0] RES_LATE  = 2'b11;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/rt_tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick on wrap.
//   clk   : clock
//   reset : synchronous active-high reset
//   clear : synchronous restart of the count at 0 (first tick TICK_DIV cycles later)
//   tick  : one-cycle pulse when the count wraps
module rt_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LastVal = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap = (cnt_q == LastVal);
  assign tick = wrap & ~clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction-time tester.
// A start rising edge (in IDLE/RESULT) latches a pseudo-random countdown; when it expires
// the stimulus LED lights and each player's first press is timestamped in ticks.
//   clk, reset   : clock, synchronous active-high reset
//   start        : level input, rising edge starts a round
//   btn          : per-player level buttons, rising edge = press
//   led          : stimulus lamp
//   state        : 0 IDLE, 1 COUNTDOWN, 2 TEST, 3 RESULT
//   done         : one-cycle pulse on entry to RESULT
//   reaction     : per-player tick count, player i at [i*CNT_W +: CNT_W]
//   result       : per-player code (none/good/early/late)
//   winner       : index of the first good player, winner_valid when one exists
module reaction_timer_multi
  import reaction_pkg::*;
#(
  parameter int unsigned PLAYERS    = 4,
  parameter int unsigned CNT_W      = 14,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned MIN_DELAY  = 1000,
  parameter int unsigned DELAY_MASK = 2047,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int unsigned WIN_W     = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PLAYERS-1:0]       btn,
  output logic                     led,
  output logic [1:0]               state,
  output logic                     done,
  output logic [PLAYERS*CNT_W-1:0] reaction,
  output logic [2*PLAYERS-1:0]     result,
  output logic [WIN_W-1:0]         winner,
  output logic                     winner_valid
);

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [31:0]      CntMask32  = (32'd1 << CNT_W) - 32'd1;

  logic [15:0]                    lfsr_q;
  logic                           start_q;
  logic [PLAYERS-1:0]             btn_q;
  state_e                         state_q;
  logic                           led_q, done_q, win_valid_q;
  logic [WIN_W-1:0]               winner_q;
  logic [CNT_W-1:0]               delay_q, up_q;
  logic [PLAYERS-1:0][1:0]        res_q;
  logic [PLAYERS-1:0][CNT_W-1:0]  rxn_q;

  logic                           start_rise, start_accept, tick;
  logic [PLAYERS-1:0]             press, new_good;
  logic [PLAYERS-1:0][1:0]        res_d, res_late;
  logic [PLAYERS-1:0][CNT_W-1:0]  rxn_d, rxn_late;
  logic                           all_graded, all_early;
  logic [WIN_W-1:0]               win_idx;
  logic [31:0]                    delay_sum;
  logic [CNT_W-1:0]               delay_sat;

  assign start_rise   = start & ~start_q;
  assign start_accept = start_rise && (state_q == StIdle || state_q == StResult);
  assign press        = btn & ~btn_q;

  // Countdown length, computed wide so the saturation check cannot overflow.
  assign delay_sum = 32'(MIN_DELAY) + (32'(lfsr_q) & 32'(DELAY_MASK) & CntMask32);
  assign delay_sat = (delay_sum > CntMask32) ? CntMax : delay_sum[CNT_W-1:0];

  rt_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (start_accept),
    .tick  (tick)
  );

  // Grade this cycle's presses; the FSM decides which of these candidates to commit.
  always_comb begin
    res_d    = res_q;
    rxn_d    = rxn_q;
    new_good = '0;
    for (int i = 0; i < int'(PLAYERS); i++) begin
      if (press[i] && res_q[i] == RES_NONE) begin
        if (state_q == StCountdown) begin
          res_d[i] = RES_EARLY;
          rxn_d[i] = CntMax;
        end else if (state_q == StTest) begin
          res_d[i]    = RES_GOOD;
          rxn_d[i]    = up_q;
          new_good[i] = 1'b1;
        end
      end
    end

    all_graded = 1'b1;
    all_early  = 1'b1;
    res_late   = res_d;
    rxn_late   = rxn_d;
    for (int i = 0; i < int'(PLAYERS); i++) begin
      if (res_d[i] == RES_NONE) begin
        all_graded  = 1'b0;
        res_late[i] = RES_LATE;
        rxn_late[i] = TimeoutVal;
      end
      if (res_d[i] != RES_EARLY) all_early = 1'b0;
    end

    // Descending scan so the lowest simultaneous index wins.
    win_idx = '0;
    for (int i = int'(PLAYERS) - 1; i >= 0; i--) begin
      if (new_good[i]) win_idx = WIN_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q      <= LFSR_SEED;
      start_q     <= 1'b0;
      btn_q       <= '0;
      state_q     <= StIdle;
      led_q       <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      winner_q    <= '0;
      delay_q     <= '0;
      up_q        <= '0;
      res_q       <= '0;
      rxn_q       <= '0;
    end else begin
      lfsr_q  <= lfsr_step(lfsr_q);
      start_q <= start;
      btn_q   <= btn;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle, StResult: begin
          if (start_accept) begin
            res_q       <= '0;
            rxn_q       <= '0;
            winner_q    <= '0;
            win_valid_q <= 1'b0;
            delay_q     <= delay_sat;
            led_q       <= 1'b0;
            state_q     <= StCountdown;
          end
        end
        StCountdown: begin
          res_q <= res_d;
          rxn_q <= rxn_d;
          if (all_early) begin
            state_q <= StResult;
            done_q  <= 1'b1;
          end else if (delay_q == '0) begin
            led_q   <= 1'b1;
            up_q    <= '0;
            state_q <= StTest;
          end else if (tick) begin
            delay_q <= delay_q - 1'b1;
          end
        end
        StTest: begin
          if (!win_valid_q && (|new_good)) begin
            winner_q    <= win_idx;
            win_valid_q <= 1'b1;
          end
          if (all_graded) begin
            res_q   <= res_d;
            rxn_q   <= rxn_d;
            led_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StResult;
          end else if (up_q == TimeoutVal) begin
            res_q   <= res_late;
            rxn_q   <= rxn_late;
            led_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StResult;
          end else begin
            res_q <= res_d;
            rxn_q <= rxn_d;
            if (tick) up_q <= up_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign led          = led_q;
  assign state        = state_q;
  assign done         = done_q;
  assign reaction     = rxn_q;
  assign result       = res_q;
  assign winner       = winner_q;
  assign winner_valid = win_valid_q;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Bench for reaction_timer_multi with a small tick divider. Each round is described by the
// posedge index (relative to the start-accept edge) at which each player's button rises;
// expected outcomes are derived from the timing rules with plain arithmetic.
module tb_reaction_timer_multi;

  localparam int NP = 4;
  localparam int CW = 14;
  localparam int TD = 4;
  localparam int TO = 10;
  localparam int MD = 3;
  localparam int DM = 0;
  localparam int EarlyRxn = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [NP-1:0]     btn;
  logic              led, done, winner_valid;
  logic [1:0]        state;
  logic [NP*CW-1:0]  reaction;
  logic [2*NP-1:0]   result;
  logic [1:0]        winner;

  int checks = 0;
  int errors = 0;
  int press_at [NP];  // 0 = never presses

  always #5 clk = ~clk;

  reaction_timer_multi #(
    .PLAYERS    (NP),
    .CNT_W      (CW),
    .TICK_DIV   (TD),
    .TIMEOUT    (TO),
    .MIN_DELAY  (MD),
    .DELAY_MASK (DM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .btn          (btn),
    .led          (led),
    .state        (state),
    .done         (done),
    .reaction     (reaction),
    .result       (result),
    .winner       (winner),
    .winner_valid (winner_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks seen before edge j, counting only ticks after led rise at edge l.
  function automatic int cnt_before(input int j, input int l);
    return (j - 1) / TD - l / TD;
  endfunction

  task automatic run_round(input string name);
    int l, tend, endj, led_at, led_fall, done_at, done_cnt, win, win_p, p;
    int exp_res [NP];
    int exp_rxn [NP];
    bit all_early, all_in;
    l    = (MD + 0) * TD + 1;  // random part is zero with DM = 0
    tend = (TO + l / TD) * TD + 1;
    all_early = 1'b1;
    all_in    = 1'b1;
    endj      = 0;
    for (int i = 0; i < NP; i++) begin
      if (!(press_at[i] >= 1 && press_at[i] <= l)) all_early = 1'b0;
      if (!(press_at[i] >= 1 && press_at[i] <= tend)) all_in = 1'b0;
      if (press_at[i] > endj) endj = press_at[i];
    end
    if (!all_early && !all_in) endj = tend;
    win = -1;
    win_p = 1 << 30;
    for (int i = 0; i < NP; i++) begin
      p = press_at[i];
      if (p >= 1 && p <= l) begin
        exp_res[i] = 2; exp_rxn[i] = EarlyRxn;
      end else if (p > l && p <= endj) begin
        exp_res[i] = 1; exp_rxn[i] = cnt_before(p, l);
        if (p < win_p) begin win = i; win_p = p; end
      end else begin
        exp_res[i] = 3; exp_rxn[i] = TO;
      end
    end

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    led_at = -1; led_fall = -1; done_at = -1; done_cnt = 0;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) if (press_at[i] == j) btn[i] = 1'b1;
      @(posedge clk);
      #1;
      if (led && led_at < 0) led_at = j;
      if (led_at >= 0 && !led && led_fall < 0) led_fall = j;
      if (done) begin done_cnt++; done_at = j; end
    end
    check({name, " led_rise"}, led_at, all_early ? -1 : l);
    check({name, " led_fall"}, led_fall, all_early ? -1 : endj);
    check({name, " done_at"}, done_at, endj);
    check({name, " done_cnt"}, done_cnt, 1);
    check({name, " state"}, 32'(state), 3);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s result[%0d]", name, i), 32'(result[2*i +: 2]), exp_res[i]);
      check($sformatf("%s reaction[%0d]", name, i), 32'(reaction[i*CW +: CW]), exp_rxn[i]);
    end
    check({name, " winner_valid"}, 32'(winner_valid), (win >= 0) ? 1 : 0);
    if (win >= 0) check({name, " winner"}, 32'(winner), win);
    @(negedge clk);
    start = 1'b0;
    btn   = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic set_press(input int a, input int b, input int c, input int d);
    press_at[0] = a; press_at[1] = b; press_at[2] = c; press_at[3] = d;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    btn   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", 32'(state), 0);
    check("reset result", 32'(result), 0);
    check("reset reaction", 32'(reaction), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check("idle state", 32'(state), 0);
      check("idle led_done", 32'({led, done, winner_valid, winner}), 0);
      check("idle outputs", 32'(|{result, reaction}), 0);
    end

    set_press(0, 0, 0, 0);       run_round("no_press");
    set_press(0, 0, 33, 0);      run_round("p2_five");
    set_press(5, 20, 25, 30);    run_round("p0_early");
    set_press(0, 22, 0, 22);     run_round("tie_1_3");
    set_press(13, 14, 53, 0);    run_round("boundary");
    set_press(1, 5, 9, 13);      run_round("all_early");
    set_press(54, 30, 0, 53);    run_round("after_end");

    // Abort mid-TEST: a press has already been graded before the reset.
    set_press(16, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) if (press_at[i] == j) btn[i] = 1'b1;
      @(posedge clk);
    end
    #1;
    check("pre_reset state", 32'(state), 2);
    check("pre_reset result0", 32'(result[1:0]), 1);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    btn   = '0;
    @(posedge clk);
    #1;
    check("mid_reset state", 32'(state), 0);
    check("mid_reset led", 32'(led), 0);
    check("mid_reset result", 32'(result), 0);
    check("mid_reset reaction", 32'(reaction), 0);
    check("mid_reset winner_valid", 32'(winner_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    set_press(0, 18, 0, 0);      run_round("after_reset");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NP; i++) begin
        press_at[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 60));
      end
      run_round($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
